serial_adder: RTL and testbench

//  Bit-serial adder: feeds one full_adder cell LSB-first, one bit per clock, with
//  a registered carry. Sits upstream of the ALU result path. Trades WIDTH cycles of

---
 rtl/serial_adder.sv | 163 ++++++++++++++++
 tb/tb_serial_adder.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder built around a single full_adder cell. Operands are
//   consumed LSB-first, one bit per clock, with the carry held in a 1-bit
//   register between cycles. A WIDTH-bit add takes WIDTH cycles in RUN,
//   followed by a single DONE cycle in which the results are presented.
//   Besides the sum and carry-out it reports signed overflow and an
//   all-propagate flag usable as a carry-skip qualifier.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request an add; only looked at while busy=0
//   inA    in   WIDTH  operand A, captured when start is accepted
//   inB    in   WIDTH  operand B, captured when start is accepted
//   cin    in   1      carry-in, captured when start is accepted
//   busy   out  1      high while the add is running
//   done   out  1      one-cycle pulse, results valid and freshly updated
//   sum    out  WIDTH  low WIDTH bits of A+B+cin
//   cout   out  1      carry out of the MSB
//   ovf    out  1      signed overflow (carry into MSB ^ carry out of MSB)
//   p_all  out  1      AND over all bits of A^B
// ---------------------------------------------------------------------------

// Single-bit full adder cell; p is the propagate term of the bit.
module full_adder (
  input  logic inA,
  input  logic inB,
  input  logic cin,
  output logic sum,
  output logic cout,
  output logic p
);

  assign p    = inA ^ inB;
  assign sum  = p ^ cin;
  assign cout = (inA & inB) | (p & cin);

endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             p_all
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] part_sum;
  logic             carry;
  logic             p_acc;
  logic [CW-1:0]    cnt;

  logic fa_sum;
  logic fa_cout;
  logic fa_p;

  logic load;
  logic last_bit;

  // A new add may be accepted from IDLE or directly out of DONE, which lets
  // operations run back-to-back without an idle cycle in between.
  assign load     = start && ((state == IDLE) || (state == DONE));
  assign last_bit = (state == RUN) && (cnt == LAST_BIT);

  full_adder u_fa (
    .inA  (a_sr[0]),
    .inB  (b_sr[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout),
    .p    (fa_p)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. Start requests seen during RUN fall through untouched.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = RUN;
      RUN:  if (cnt == LAST_BIT) next_state = DONE;
      DONE: next_state = start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Status outputs decoded straight from the state.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Datapath. Each RUN cycle the cell's sum bit enters the top of the partial
  // sum register, so after WIDTH cycles the LSB has reached bit 0. The visible
  // results are only written on the final RUN edge; the carry register on that
  // edge is exactly the carry into the MSB, which gives the overflow term.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      part_sum <= '0;
      carry    <= 1'b0;
      p_acc    <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
      p_all    <= 1'b0;
    end else if (load) begin
      a_sr     <= inA;
      b_sr     <= inB;
      carry    <= cin;
      p_acc    <= 1'b1;
      cnt      <= '0;
      part_sum <= '0;
    end else if (state == RUN) begin
      a_sr     <= a_sr >> 1;
      b_sr     <= b_sr >> 1;
      carry    <= fa_cout;
      p_acc    <= p_acc & fa_p;
      part_sum <= {fa_sum, part_sum[WIDTH-1:1]};
      cnt      <= cnt + CW'(1);
      if (last_bit) begin
        sum   <= {fa_sum, part_sum[WIDTH-1:1]};
        cout  <= fa_cout;
        ovf   <= carry ^ fa_cout;
        p_all <= p_acc & fa_p;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//   Self-checking bench for serial_adder (WIDTH=8). Each accepted start pushes
//   the arithmetically expected result onto a scoreboard queue; the entry is
//   popped and compared when done rises. Outputs are sampled on the falling
//   clock edge, away from the active edge.
// ---------------------------------------------------------------------------
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             p_all;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             p_all;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] held_sum;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .inA   (in_a),
    .inB   (in_b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf),
    .p_all (p_all)
  );

  always #5 clk = ~clk;

  // Reference: plain wide addition, plus a second addition of the low bits
  // only to find the carry into the MSB.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic c);
    exp_t e;
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] low;
    full    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    low     = {1'b0, a[WIDTH-2:0]} + {1'b0, b[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, c};
    e.sum   = full[WIDTH-1:0];
    e.cout  = full[WIDTH];
    e.ovf   = low[WIDTH-1] ^ full[WIDTH];
    e.p_all = &(a ^ b);
    return e;
  endfunction

  // Drive a start request (call while at a falling edge) and record the
  // expected result.
  task automatic push_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic c);
    in_a  = a;
    in_b  = b;
    cin   = c;
    start = 1'b1;
    sb.push_back(model(a, b, c));
  endtask

  task automatic scramble_inputs();
    in_a = WIDTH'($urandom);
    in_b = WIDTH'($urandom);
    cin  = 1'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    start = 1'b0;
    in_a  = '0;
    in_b  = '0;
    cin   = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, sum, cout, ovf, p_all} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b p_all=%b, want all 0",
               busy, done, sum, cout, ovf, p_all);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_hold: got busy=%b done=%b, want 0 0", busy, done);
    end
    rst_n = 1'b1;
    held_sum = '0;
  endtask

  // One full add: latency, busy during RUN, held outputs during RUN, result,
  // and the single-cycle done pulse.
  task automatic test_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic c, input string name);
    exp_t e;
    int   j;
    bit   found;
    @(negedge clk);
    push_start(a, b, c);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    scramble_inputs();
    found = 1'b0;
    j = 0;
    while (!found && j <= WIDTH + 3) begin
      if (done) begin
        found = 1'b1;
      end else begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("[TB] FAIL %s busy_run: cycle %0d got busy=%b want 1", name, j, busy);
        end
        checks++;
        if (sum !== held_sum) begin
          errors++;
          $display("[TB] FAIL %s sum_hold: cycle %0d got sum=%h want %h", name, j, sum, held_sum);
        end
        @(negedge clk);
        j++;
      end
    end
    e = sb.pop_front();
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL %s timeout: no done within %0d cycles, want %0d", name, j, WIDTH);
      return;
    end
    checks++;
    if (j !== WIDTH) begin
      errors++;
      $display("[TB] FAIL %s latency: got %0d want %0d", name, j, WIDTH);
    end
    checks++;
    if (sum !== e.sum) begin
      errors++;
      $display("[TB] FAIL %s sum: got %h want %h", name, sum, e.sum);
    end
    checks++;
    if (cout !== e.cout) begin
      errors++;
      $display("[TB] FAIL %s cout: got %b want %b", name, cout, e.cout);
    end
    checks++;
    if (ovf !== e.ovf) begin
      errors++;
      $display("[TB] FAIL %s ovf: got %b want %b", name, ovf, e.ovf);
    end
    checks++;
    if (p_all !== e.p_all) begin
      errors++;
      $display("[TB] FAIL %s p_all: got %b want %b", name, p_all, e.p_all);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s busy_done: got %b want 0", name, busy);
    end
    held_sum = e.sum;
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00 || sum !== e.sum) begin
      errors++;
      $display("[TB] FAIL %s after_done: got done=%b busy=%b sum=%h want 0 0 %h",
               name, done, busy, sum, e.sum);
    end
  endtask

  task automatic test_directed();
    test_add(8'h5A, 8'h3C, 1'b0, "case_5a_3c");
    test_add(8'hFF, 8'h01, 1'b0, "case_ff_01");
    test_add(8'hAA, 8'h55, 1'b1, "case_aa_55");
    test_add(8'h7F, 8'h01, 1'b0, "case_pos_ovf");
    test_add(8'h80, 8'h80, 1'b0, "case_neg_ovf");
  endtask

  // A start pulse mid-run must be ignored entirely.
  task automatic test_ignore_start();
    exp_t e;
    int   j;
    int   extra;
    bit   found;
    @(negedge clk);
    push_start(8'h10, 8'h20, 1'b0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    j = 0;
    while (!found && j <= WIDTH + 3) begin
      if (done) begin
        found = 1'b1;
      end else begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("[TB] FAIL ignore_start busy: cycle %0d got %b want 1", j, busy);
        end
        @(negedge clk);
        j++;
        if (j == 2) begin
          in_a  = 8'hFF;
          in_b  = 8'hFF;
          cin   = 1'b1;
          start = 1'b1;
        end else if (j == 3) begin
          start = 1'b0;
        end
      end
    end
    e = sb.pop_front();
    checks++;
    if (!found || j !== WIDTH) begin
      errors++;
      $display("[TB] FAIL ignore_start latency: found=%b cycles=%0d want %0d", found, j, WIDTH);
    end
    checks++;
    if (sum !== e.sum || cout !== e.cout) begin
      errors++;
      $display("[TB] FAIL ignore_start result: got sum=%h cout=%b want %h %b", sum, cout, e.sum, e.cout);
    end
    held_sum = e.sum;
    extra = 0;
    repeat (2 * WIDTH) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("[TB] FAIL ignore_start second_op: got %0d busy/done cycles want 0", extra);
    end
  endtask

  // Start issued during the DONE cycle launches the next add immediately.
  task automatic test_back_to_back();
    exp_t e;
    int   j;
    bit   found;
    @(negedge clk);
    push_start(8'h33, 8'h44, 1'b1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    j = 0;
    while (!done && j <= WIDTH + 3) begin
      @(negedge clk);
      j++;
    end
    e = sb.pop_front();
    checks++;
    if (!done || sum !== e.sum) begin
      errors++;
      $display("[TB] FAIL b2b first: done=%b sum=%h want 1 %h", done, sum, e.sum);
    end
    held_sum = e.sum;
    push_start(8'h01, 8'h01, 1'b0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    scramble_inputs();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b restart: got busy=%b done=%b want 1 0", busy, done);
    end
    found = 1'b0;
    j = 0;
    while (!found && j <= WIDTH + 3) begin
      if (done) found = 1'b1;
      else begin
        @(negedge clk);
        j++;
      end
    end
    e = sb.pop_front();
    checks++;
    if (!found || j !== WIDTH) begin
      errors++;
      $display("[TB] FAIL b2b latency: found=%b cycles=%0d want %0d", found, j, WIDTH);
    end
    checks++;
    if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf || p_all !== e.p_all) begin
      errors++;
      $display("[TB] FAIL b2b second: got %h/%b/%b/%b want %h/%b/%b/%b",
               sum, cout, ovf, p_all, e.sum, e.cout, e.ovf, e.p_all);
    end
    held_sum = e.sum;
    @(negedge clk);
  endtask

  // Reset in the middle of a run clears everything at once, with no done.
  task automatic test_reset_abort();
    int j;
    int seen;
    test_add(8'hC0, 8'h80, 1'b0, "pre_abort");
    @(negedge clk);
    push_start(8'hF0, 8'h0F, 1'b1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (j = 0; j < 4; j++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    void'(sb.pop_front());
    checks++;
    if ({busy, done, sum, cout, ovf, p_all} !== '0) begin
      errors++;
      $display("[TB] FAIL abort_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b p_all=%b want all 0",
               busy, done, sum, cout, ovf, p_all);
    end
    held_sum = '0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (2 * WIDTH) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("[TB] FAIL abort_no_done: got %0d busy/done cycles want 0", seen);
    end
    test_add(8'h21, 8'h13, 1'b1, "post_abort");
  endtask

  task automatic test_random();
    for (int n = 0; n < 1000; n++) begin
      test_add(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
